// File: rtl/lv_lbist_pkg.sv
// Shared types and parameter legality helper for the LV logic-BIST sequencer.
package lv_lbist_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEL  = 3'd1,
      REQ  = 3'd2,
      GAP  = 3'd3,
      DONE = 3'd4
   } lv_lbist_st_e;

   // True when the parameter set describes a sequencer that can be built.
   function automatic logic lv_lbist_params_ok(input int ch_num, input int req_num,
                                               input int pass_min, input int tmo_cyc);
      return (ch_num >= 32'sd1) && (ch_num <= 32'sd16) &&
             (req_num >= 32'sd1) &&
             (pass_min >= 32'sd1) && (pass_min <= req_num) &&
             (tmo_cyc >= 32'sd2);
   endfunction

endpackage

// File: rtl/lv_lbist_txn_tmr.sv
// Per-transaction timeout counter plus per-channel transaction/OK counters.
// txn_done/txn_ok/chan_done describe the current cycle; ok_cnt is the OK count
// of the transactions already completed on the channel (excluding this cycle).
module lv_lbist_txn_tmr
   import lv_lbist_pkg::*;
#(
   parameter  int REQ_NUM = 4,
   parameter  int TMO_CYC = 16,
   localparam int CW      = $clog2(REQ_NUM + 1),
   localparam int TW      = $clog2(TMO_CYC)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          start,
   input  logic          active,
   input  logic          ack,
   input  logic          err,
   output logic          txn_done,
   output logic          txn_ok,
   output logic          chan_done,
   output logic [CW-1:0] ok_cnt
);

   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
   localparam logic [CW-1:0] REQ_MAX  = CW'(REQ_NUM);

   logic [TW-1:0] tmo_r;
   logic [CW-1:0] txn_r;
   logic [CW-1:0] ok_r;
   logic [CW-1:0] txn_inc_s;
   logic          tmo_hit_s;

   // Completion decode: an ack always wins, even in the expiry cycle
   always_comb begin
      tmo_hit_s = (tmo_r == TMO_LAST);
      txn_done  = active & (ack | tmo_hit_s);
      txn_ok    = active & ack & ~err;
      if (txn_r < REQ_MAX) begin
         txn_inc_s = txn_r + CW'(1);
      end else begin
         txn_inc_s = txn_r;
      end
      chan_done = txn_done & (txn_inc_s == REQ_MAX);
      ok_cnt    = ok_r;
   end

   // Timeout runs only while a request is outstanding; counters restart per channel
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_r <= '0;
         txn_r <= '0;
         ok_r  <= '0;
      end else begin
         if (!active || txn_done) begin
            tmo_r <= '0;
         end else begin
            tmo_r <= tmo_r + TW'(1);
         end
         if (start) begin
            txn_r <= '0;
            ok_r  <= '0;
         end else if (txn_done) begin
            txn_r <= txn_inc_s;
            if (txn_ok && (ok_r < REQ_MAX)) begin
               ok_r <= ok_r + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/lv_lbist_seq.sv
// LV logic-BIST sequencer: walks the enabled channels in index order, issues
// REQ_NUM timed request/ack transactions to each and records a pass/fail verdict.
module lv_lbist_seq
   import lv_lbist_pkg::*;
#(
   parameter int CH_NUM   = 2,
   parameter int REQ_NUM  = 4,
   parameter int PASS_MIN = 3,
   parameter int TMO_CYC  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_bist_en,
   input  logic [CH_NUM-1:0] i_ch_mask,
   output logic [CH_NUM-1:0] o_ch_req,
   input  logic [CH_NUM-1:0] i_ch_ack,
   input  logic [CH_NUM-1:0] i_ch_err,
   output logic              o_bist_busy,
   output logic              o_bist_done,
   output logic              o_bist_fail,
   output logic [CH_NUM-1:0] o_ch_fail
);

   localparam int PW  = $clog2(CH_NUM + 1);
   localparam int CW  = $clog2(REQ_NUM + 1);
   localparam int CW1 = CW + 1;
   localparam logic [CW:0] PASS_LIM = CW1'(PASS_MIN);

   if (!lv_lbist_params_ok(CH_NUM, REQ_NUM, PASS_MIN, TMO_CYC)) begin : g_param_err
      $error("lv_lbist_seq: illegal CH_NUM/REQ_NUM/PASS_MIN/TMO_CYC combination");
   end

   lv_lbist_st_e      state_r;
   logic              bist_en_r;
   logic [CH_NUM-1:0] mask_r;
   logic [PW-1:0]     ptr_r;
   logic [CH_NUM-1:0] ch_oh_r;
   logic [CH_NUM-1:0] req_r;
   logic              busy_r;
   logic              done_r;
   logic              bist_fail_r;
   logic [CH_NUM-1:0] ch_fail_r;

   logic              found_s;
   logic [PW-1:0]     sel_idx_s;
   logic [CH_NUM-1:0] sel_oh_s;
   logic              ack_s;
   logic              err_s;
   logic              active_s;
   logic              chan_start_s;
   logic              ok_low_s;
   logic              txn_done_s;
   logic              txn_ok_s;
   logic              chan_done_s;
   logic [CW-1:0]     ok_cnt_s;

   // Lowest enabled channel at or above the pointer (scan high-to-low, last hit wins)
   always_comb begin
      found_s   = 1'b0;
      sel_idx_s = '0;
      sel_oh_s  = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (mask_r[i] && (PW'(i) >= ptr_r)) begin
            found_s     = 1'b1;
            sel_idx_s   = PW'(i);
            sel_oh_s    = '0;
            sel_oh_s[i] = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Only the requested channel's ack/err count, and only while its req is high
   always_comb begin
      ack_s        = |(i_ch_ack & req_r);
      err_s        = |(i_ch_err & req_r);
      active_s     = (state_r == REQ);
      chan_start_s = (state_r == SEL) && found_s;
      ok_low_s     = (({1'b0, ok_cnt_s} + {{CW{1'b0}}, txn_ok_s}) < PASS_LIM);
   end

   lv_lbist_txn_tmr #(
      .REQ_NUM (REQ_NUM),
      .TMO_CYC (TMO_CYC)
   ) u_txn_tmr (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .start     (chan_start_s),
      .active    (active_s),
      .ack       (ack_s),
      .err       (err_s),
      .txn_done  (txn_done_s),
      .txn_ok    (txn_ok_s),
      .chan_done (chan_done_s),
      .ok_cnt    (ok_cnt_s)
   );

   // Sequencer FSM with channel pointer and registered verdict outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= IDLE;
         bist_en_r   <= 1'b0;
         mask_r      <= '0;
         ptr_r       <= '0;
         ch_oh_r     <= '0;
         req_r       <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         bist_fail_r <= 1'b0;
         ch_fail_r   <= '0;
      end else begin
         bist_en_r <= i_bist_en;
         done_r    <= 1'b0;
         if ((state_r != IDLE) && !i_bist_en) begin
            state_r     <= IDLE;
            req_r       <= '0;
            busy_r      <= 1'b0;
            ch_fail_r   <= '0;
            bist_fail_r <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  req_r  <= '0;
                  busy_r <= 1'b0;
                  if (i_bist_en && !bist_en_r) begin
                     mask_r      <= i_ch_mask;
                     ptr_r       <= '0;
                     ch_fail_r   <= '0;
                     bist_fail_r <= 1'b0;
                     busy_r      <= 1'b1;
                     state_r     <= SEL;
                  end
               end
               SEL: begin
                  if (found_s) begin
                     ptr_r   <= sel_idx_s;
                     ch_oh_r <= sel_oh_s;
                     req_r   <= sel_oh_s;
                     state_r <= REQ;
                  end else begin
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                     bist_fail_r <= |ch_fail_r;
                     state_r     <= DONE;
                  end
               end
               REQ: begin
                  if (txn_done_s) begin
                     req_r <= '0;
                     if (chan_done_s) begin
                        ch_fail_r <= ch_fail_r | (ch_oh_r & {CH_NUM{ok_low_s}});
                        ptr_r     <= ptr_r + PW'(1);
                        state_r   <= SEL;
                     end else begin
                        state_r <= GAP;
                     end
                  end
               end
               GAP: begin
                  req_r   <= ch_oh_r;
                  state_r <= REQ;
               end
               DONE: begin
                  state_r <= DONE;
               end
               default: begin
                  req_r   <= '0;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_ch_req    = req_r;
   assign o_bist_busy = busy_r;
   assign o_bist_done = done_r;
   assign o_bist_fail = bist_fail_r;
   assign o_ch_fail   = ch_fail_r;

endmodule

// File: tb/tb_lv_lbist_seq.sv
// Bench for lv_lbist_seq: a schedule model builds the expected output
// timeline of each run from the transaction plan; a negedge process compares.
module tb_lv_lbist_seq;

   localparam int MAXK     = 200;
   localparam int REQN     = 4;
   localparam int PASSN    = 3;
   localparam int TMON     = 16;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_bist_en;
   logic [1:0] i_ch_mask;
   logic [1:0] o_ch_req;
   logic [1:0] i_ch_ack;
   logic [1:0] i_ch_err;
   logic       o_bist_busy;
   logic       o_bist_done;
   logic       o_bist_fail;
   logic [1:0] o_ch_fail;

   lv_lbist_seq #(.CH_NUM(2), .REQ_NUM(REQN), .PASS_MIN(PASSN), .TMO_CYC(TMON)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_bist_en   (i_bist_en),
      .i_ch_mask   (i_ch_mask),
      .o_ch_req    (o_ch_req),
      .i_ch_ack    (i_ch_ack),
      .i_ch_err    (i_ch_err),
      .o_bist_busy (o_bist_busy),
      .o_bist_done (o_bist_done),
      .o_bist_fail (o_bist_fail),
      .o_ch_fail   (o_ch_fail)
   );

   int   n_assert = 0;
   int   n_fail   = 0;
   int   k_cur    = 0;
   bit   chk_on   = 1'b0;
   bit   noise    = 1'b0;

   // plan: per channel, per transaction, ack in the n-th req-high cycle (0 = never)
   logic [1:0] plan_mask;
   int         plan_ack [2][4];
   bit         plan_err [2][4];

   logic [1:0] e_req  [MAXK+1];
   bit         e_busy [MAXK+1];
   bit         e_done [MAXK+1];
   bit         e_fail [MAXK+1];
   logic [1:0] e_chf  [MAXK+1];

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (k=%0d): got %0h expected %0h", nm, k_cur, act, exp);
      end
   endtask

   // compare DUT outputs against the model timeline in the middle of each cycle
   always @(negedge i_clk) begin
      if (chk_on) begin
         chk("o_ch_req",    32'(o_ch_req),    32'(e_req[k_cur]));
         chk("o_bist_busy", 32'(o_bist_busy), 32'(e_busy[k_cur]));
         chk("o_bist_done", 32'(o_bist_done), 32'(e_done[k_cur]));
         chk("o_bist_fail", 32'(o_bist_fail), 32'(e_fail[k_cur]));
         chk("o_ch_fail",   32'(o_ch_fail),   32'(e_chf[k_cur]));
      end
   end

   task automatic set_plan(input logic [1:0] mask, input int a0, input int a1,
                           input logic [3:0] err0, input logic [3:0] err1);
      plan_mask = mask;
      for (int j = 0; j < 4; j++) begin
         plan_ack[0][j] = a0;
         plan_ack[1][j] = a1;
         plan_err[0][j] = err0[j];
         plan_err[1][j] = err1[j];
      end
   endtask

   // Timeline from the run rules: k=0 start sampled, k=1 select, each channel
   // is a train of req bursts (ack length or full timeout) separated by one
   // low cycle, then one select cycle; done pulse after the last select.
   task automatic build_model(output int done_k);
      int         t;
      int         ok;
      int         len;
      logic [1:0] chf;
      for (int k = 0; k <= MAXK; k++) begin
         e_req[k] = 2'b00; e_busy[k] = 1'b0; e_done[k] = 1'b0;
         e_fail[k] = 1'b0; e_chf[k] = 2'b00;
      end
      e_busy[1] = 1'b1;
      t   = 2;
      chf = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
         if (plan_mask[ch]) begin
            ok = 0;
            for (int j = 0; j < REQN; j++) begin
               len = (plan_ack[ch][j] == 0) ? TMON : plan_ack[ch][j];
               for (int c = 0; c < len; c++) begin
                  e_req[t+c]  = 2'b01 << ch;
                  e_busy[t+c] = 1'b1;
                  e_chf[t+c]  = chf;
               end
               t += len;
               if (plan_ack[ch][j] != 0 && !plan_err[ch][j]) ok++;
               if (j < REQN - 1) begin
                  e_busy[t] = 1'b1;
                  e_chf[t]  = chf;
                  t++;
               end
            end
            if (ok < PASSN) chf[ch] = 1'b1;
            e_busy[t] = 1'b1;
            e_chf[t]  = chf;
            t++;
         end
      end
      done_k = t;
      e_done[t] = 1'b1;
      for (int k = t; k <= MAXK; k++) begin
         e_chf[k]  = chf;
         e_fail[k] = |chf;
      end
   endtask

   // One run: enable, respond to requests from the plan, drop enable at
   // abort_at (or 3 cycles after done), then check 3 more idle cycles.
   task automatic run_test(input int abort_at, output int done_k);
      int en_low_at;
      int rc;
      int ch;
      int last_ch;
      int tix [2];
      build_model(done_k);
      en_low_at = (abort_at >= 0) ? abort_at : done_k + 3;
      for (int k = en_low_at + 1; k <= MAXK; k++) begin
         e_req[k] = 2'b00; e_busy[k] = 1'b0; e_done[k] = 1'b0;
         e_fail[k] = 1'b0; e_chf[k] = 2'b00;
      end
      i_ch_mask = plan_mask;
      @(posedge i_clk);
      #1;
      i_bist_en = 1'b1;
      k_cur   = 0;
      chk_on  = 1'b1;
      rc      = 0;
      last_ch = 0;
      tix[0]  = 0;
      tix[1]  = 0;
      for (int k = 0; k <= en_low_at + 3; k++) begin
         if (k > 0) begin
            @(posedge i_clk);
            #1;
            k_cur = k;
         end
         if (k == en_low_at) i_bist_en = 1'b0;
         i_ch_ack = noise ? 2'b11 : 2'b00;
         i_ch_err = noise ? 2'b11 : 2'b00;
         if (o_ch_req != 2'b00) begin
            ch      = o_ch_req[1] ? 1 : 0;
            last_ch = ch;
            rc++;
            i_ch_ack[ch] = 1'b0;
            i_ch_err[ch] = noise;
            if (tix[ch] < REQN && plan_ack[ch][tix[ch]] == rc) begin
               i_ch_ack[ch] = 1'b1;
               i_ch_err[ch] = plan_err[ch][tix[ch]];
            end
         end else if (rc > 0) begin
            tix[last_ch]++;
            rc = 0;
         end
      end
      @(negedge i_clk);
      #1;
      chk_on   = 1'b0;
      i_ch_ack = 2'b00;
      i_ch_err = 2'b00;
      repeat (2) @(posedge i_clk);
   endtask

   initial begin
      int dk;
      int nd;
      i_rst_n   = 1'b0;
      i_bist_en = 1'b0;
      i_ch_mask = 2'b00;
      i_ch_ack  = 2'b00;
      i_ch_err  = 2'b00;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_req",  32'(o_ch_req),    32'd0);
      chk("rst_busy", 32'(o_bist_busy), 32'd0);
      chk("rst_done", 32'(o_bist_done), 32'd0);
      chk("rst_fail", 32'(o_bist_fail), 32'd0);
      chk("rst_chf",  32'(o_ch_fail),   32'd0);
      i_rst_n = 1'b1;
      repeat (2) @(posedge i_clk);

      // all channels, all acks clean
      noise = 1'b0;
      set_plan(2'b11, 1, 1, 4'b0000, 4'b0000);
      run_test(-1, dk);
      chk("t1_done_k", 32'(dk), 32'd18);
      chk("t1_chf", 32'(e_chf[dk]), 32'd0);

      // ch1 errors on two acks, with noise on idle channels and gaps
      noise = 1'b1;
      set_plan(2'b11, 2, 2, 4'b0000, 4'b1010);
      run_test(-1, dk);
      chk("t2_done_k", 32'(dk), 32'd26);
      chk("t2_chf", 32'(e_chf[dk]), 32'd2);
      chk("t2_fail", 32'(e_fail[dk]), 32'd1);

      // ch0 never acks: four full timeouts
      noise = 1'b0;
      set_plan(2'b11, 0, 1, 4'b0000, 4'b0000);
      run_test(-1, dk);
      chk("t3_done_k", 32'(dk), 32'd78);
      chk("t3_chf", 32'(e_chf[dk]), 32'd1);

      // one error out of four passes; ack in the expiry cycle counts OK
      set_plan(2'b11, 3, 16, 4'b0100, 4'b0000);
      run_test(-1, dk);
      chk("t4_done_k", 32'(dk), 32'd86);
      chk("t4_chf", 32'(e_chf[dk]), 32'd0);

      // no channels enabled
      set_plan(2'b00, 1, 1, 4'b0000, 4'b0000);
      run_test(-1, dk);
      chk("t5_done_k", 32'(dk), 32'd2);

      // only ch1 enabled
      set_plan(2'b10, 1, 1, 4'b0000, 4'b0000);
      run_test(-1, dk);
      chk("t6_done_k", 32'(dk), 32'd10);

      // abort after two ch0 acks
      set_plan(2'b11, 2, 2, 4'b0000, 4'b0000);
      run_test(8, dk);
      nd = 0;
      for (int k = 0; k <= MAXK; k++) nd += int'(e_done[k]);
      chk("t7_no_done", 32'(nd), 32'd0);

      // restart after abort from ch0 with fresh counters
      set_plan(2'b11, 1, 1, 4'b0000, 4'b0000);
      run_test(-1, dk);
      chk("t8_done_k", 32'(dk), 32'd18);

      // asynchronous reset in the middle of a request burst
      i_ch_mask = 2'b11;
      @(posedge i_clk);
      #1;
      i_bist_en = 1'b1;
      repeat (4) @(posedge i_clk);
      #1;
      chk("t9_req_pre", 32'(o_ch_req), 32'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("t9_req",  32'(o_ch_req),    32'd0);
      chk("t9_busy", 32'(o_bist_busy), 32'd0);
      chk("t9_done", 32'(o_bist_done), 32'd0);
      chk("t9_fail", 32'(o_bist_fail), 32'd0);
      chk("t9_chf",  32'(o_ch_fail),   32'd0);
      i_bist_en = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (2) @(posedge i_clk);

      // clean run after reset recovery
      set_plan(2'b10, 1, 1, 4'b0000, 4'b0000);
      run_test(-1, dk);
      chk("t10_done_k", 32'(dk), 32'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lv_lbist_seq.md
# lv_lbist_seq

Parametrised LV logic-BIST sequencer and successor to the single-pass LV self-test controller. It runs CH_NUM independent self-test channels in turn, for example the OWT watchdog loop, the scan-register check and future checkers. Each channel gets REQ_NUM request/ack transactions, each transaction has its own timeout, and each channel's OK count is checked against a pass threshold. The block sits in lv_top between the mode controller (i_bist_en) and the channel checkers. It reports a per-channel fail vector plus an aggregate fail and done pulse.

## Interface
- CH_NUM, 2, number of test channels (1..16)
- REQ_NUM, 4, transactions issued per channel (≥1)
- PASS_MIN, 3, minimum OK transactions for a channel pass (1..REQ_NUM)
- TMO_CYC, 16, cycles a request may wait for ack before timeout (≥2)
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_bist_en  in  1  level; rising edge starts a run, low aborts/clears
- i_ch_mask  in  CH_NUM  channel enable, sampled at start
- o_ch_req  out  CH_NUM  one-hot request to active channel
- i_ch_ack  in  CH_NUM  per-channel ack, 1-cycle pulse
- i_ch_err  in  CH_NUM  per-channel error, qualified by ack
- o_bist_busy  out  1  run in progress (SEL/REQ/GAP)
- o_bist_done  out  1  1-cycle pulse at run completion
- o_bist_fail  out  1  OR of o_ch_fail, valid from done, held
- o_ch_fail  out  CH_NUM  per-channel verdict, held

## Operation
- All outputs reset to 0. State resets to IDLE.
- IDLE: waits for i_bist_en=1 with registered i_bist_en=0.
  - On that edge: latch i_ch_mask, clear channel pointer, counters and fail vector; go to SEL.
- SEL: finds the lowest channel index ≥ pointer with mask bit set.
  - If found: load pointer, clear txn/ok counters, go to REQ.
  - If none: go to DONE.
- REQ: o_ch_req[ptr]=1 and the timeout counter increments.
  - i_ch_ack[ptr]=1 completes the transaction. It counts OK when i_ch_err[ptr]=0.
  - If the timeout counter reaches TMO_CYC-1 without ack, the transaction completes as error.
  - After completion: txn_cnt+1. If txn_cnt now equals REQ_NUM, write o_ch_fail[ptr]=(ok_cnt<PASS_MIN), set ptr+1 and go to SEL. Otherwise go to GAP.
- GAP: one cycle with req low, then REQ.
- DONE: o_bist_done pulses in the entry cycle only. o_bist_fail=|o_ch_fail. The block stays in DONE until i_bist_en=0.
- i_bist_en=0 in any non-IDLE state aborts:
  - next cycle IDLE, req low, busy low;
  - o_ch_fail and o_bist_fail cleared;
  - no done pulse.
- Acks and errors on non-active channels, and acks while req is low, are ignored.
- Counter widths:
  - txn/ok counters are $clog2(REQ_NUM+1) bits, saturating;
  - timeout counter is $clog2(TMO_CYC) bits;
  - channel pointer is $clog2(CH_NUM+1) bits.

## Timing
- Start: edge sampled at cycle T; SEL at T+1; first o_ch_req high at T+2.
- Ack sampled at cycle A: req is low at A+1 (GAP) and high again at A+2.
  - There is always a ≥1-cycle req-low gap between transactions.
- Channel end at A: o_ch_fail bit valid at A+1 (SEL). The next channel's req is high at A+2; otherwise DONE and o_bist_done at A+2.
- Timeout: a request with no ack stays high for exactly TMO_CYC cycles.
- An ack in the timeout-expiry cycle wins: it counts as a real ack and its err is honoured.
- i_ch_mask=0: done at T+2, o_bist_fail=0, no requests issued.
- Abort and restart: a new rising edge after abort starts from channel 0 with all counters cleared.
- Asynchronous reset mid-run: all outputs are 0 immediately.

## Structure
- lv_lbist_pkg holds the state enum lv_lbist_st_e {IDLE, SEL, REQ, GAP, DONE} and parameter legality checks (as elaboration $error).
- Sub-module lv_lbist_txn_tmr: the timeout counter plus txn/ok counters. It takes start, ack, err and outputs txn_done, txn_ok, chan_done and ok_cnt.
- Top-level lv_lbist_seq holds the FSM, mask/pointer logic, priority select and result registers.

## Test plan
- Default parameters, mask=2'b11, all acks with err=0 → 4 reqs on ch0 then 4 on ch1; done pulse; o_ch_fail=2'b00, o_bist_fail=0.
- ch1 returns err on 2 of 4 acks → ok=2<3; o_ch_fail=2'b10, o_bist_fail=1; the ch0 bit is valid at the cycle after its 4th ack.
- ch0 never acks → 4 timeouts, each with req high for exactly 16 cycles plus a 1-cycle gap; o_ch_fail[0]=1; ch1 then runs normally.
- Boundary cases:
  - ack with err on exactly 1 of 4 → ok=3=PASS_MIN → pass;
  - an ack coinciding with the 16th req cycle counts OK.
- mask=2'b00 → o_bist_done at T+2, no o_ch_req activity, fail=0. mask=2'b10 → only ch1 requested.
- Abort after 2 ch0 acks → req and busy low next cycle, no done, fail vector 0. Re-enable → restart at ch0 with 4 fresh requests.
